// File: rtl/time_entry_ctrl_pkg.sv
// Shared types and constants for the alarm-clock time-entry sequencer.
package time_entry_ctrl_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned BUF_W   = 16;
    localparam int unsigned CNT_W   = 5;

    // Key code meaning "no key"; every code at or above it is treated the same.
    localparam logic [DIGIT_W-1:0] NOKEY = 4'd10;

    // Upper limits used by the HH:MM range check.
    localparam logic [DIGIT_W-1:0] LIM_TWO   = 4'd2;
    localparam logic [DIGIT_W-1:0] LIM_THREE = 4'd3;
    localparam logic [DIGIT_W-1:0] LIM_FIVE  = 4'd5;
    localparam logic [DIGIT_W-1:0] LIM_NINE  = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_KEY_STORE  = 3'd1,
        ST_KEY_WAIT   = 3'd2,
        ST_KEY_ENTRY  = 3'd3,
        ST_SET_TIME   = 3'd4,
        ST_SET_ALARM  = 3'd5,
        ST_SHOW_ALARM = 3'd6
    } state_t;

    // Candidate time held in the entry buffer, oldest digit in the MSBs.
    typedef struct packed {
        logic [DIGIT_W-1:0] ms_hr;
        logic [DIGIT_W-1:0] ls_hr;
        logic [DIGIT_W-1:0] ms_min;
        logic [DIGIT_W-1:0] ls_min;
    } hhmm_t;

    function automatic logic is_digit(input logic [DIGIT_W-1:0] k);
        return k < NOKEY;
    endfunction

endpackage

// File: rtl/time_entry_ctrl_key_shift_reg.sv
// Four-digit BCD entry buffer with shift/clear controls and HH:MM range check.
module time_entry_ctrl_key_shift_reg
    import time_entry_ctrl_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_shift,
    input  logic               i_clear,
    input  logic [DIGIT_W-1:0] i_digit,
    output hhmm_t              o_time,
    output logic               o_valid_c
);

    hhmm_t              r_buf;
    logic [DIGIT_W-1:0] w_ls_hr_lim;

    // Shift the newest digit in at the low end; clear wins over shift.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_buf <= '0;
        end else if (i_clear) begin
            r_buf <= '0;
        end else if (i_shift) begin
            r_buf <= BUF_W'({r_buf.ls_hr, r_buf.ms_min, r_buf.ls_min, i_digit});
        end
    end

    // Hours tens digit of 2 limits the hours units digit to 3.
    assign w_ls_hr_lim = (r_buf.ms_hr == LIM_TWO) ? LIM_THREE : LIM_NINE;

    assign o_valid_c = (r_buf.ms_hr  <= LIM_TWO)     &&
                       (r_buf.ls_hr  <= w_ls_hr_lim) &&
                       (r_buf.ms_min <= LIM_FIVE)    &&
                       (r_buf.ls_min <= LIM_NINE);

    assign o_time = r_buf;

endmodule

// File: rtl/time_entry_ctrl.sv
// Keypad/button sequencer: collects HH:MM digits and strobes time or alarm loads.
module time_entry_ctrl
    import time_entry_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_SEC = 10
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               one_second,
    input  logic [DIGIT_W-1:0] key,
    input  logic               time_button,
    input  logic               alarm_button,
    output logic [DIGIT_W-1:0] new_time_ms_hr,
    output logic [DIGIT_W-1:0] new_time_ls_hr,
    output logic [DIGIT_W-1:0] new_time_ms_min,
    output logic [DIGIT_W-1:0] new_time_ls_min,
    output logic               load_new_c,
    output logic               load_new_a,
    output logic               show_new_time,
    output logic               show_alarm,
    output logic               entry_error
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_SEC);

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [DIGIT_W-1:0] r_key;
    logic               r_load_new_c;
    logic               r_load_new_a;
    logic               r_entry_error;
    logic               r_show_new_time;
    logic               r_show_alarm;

    logic               w_in_entry;
    logic               w_timeout;
    logic               w_shift;
    logic               w_clear;
    logic               w_valid;
    hhmm_t              w_time;

    assign w_in_entry = (r_state == ST_KEY_WAIT) || (r_state == ST_KEY_ENTRY);
    assign w_timeout  = (r_count == TIMEOUT_CNT);
    assign w_shift    = (r_state == ST_KEY_STORE);
    // Every path back into IDLE from an entry state empties the buffer.
    assign w_clear    = (r_state == ST_SET_TIME) || (r_state == ST_SET_ALARM) ||
                        (w_in_entry && w_timeout);

    time_entry_ctrl_key_shift_reg u_key_shift_reg (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_shift   (w_shift),
        .i_clear   (w_clear),
        .i_digit   (r_key),
        .o_time    (w_time),
        .o_valid_c (w_valid)
    );

    // Sequencer state, inactivity counter and registered Moore outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_count         <= '0;
            r_key           <= '0;
            r_load_new_c    <= 1'b0;
            r_load_new_a    <= 1'b0;
            r_entry_error   <= 1'b0;
            r_show_new_time <= 1'b0;
            r_show_alarm    <= 1'b0;
        end else begin
            r_load_new_c  <= 1'b0;
            r_load_new_a  <= 1'b0;
            r_entry_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_count <= '0;
                    if (is_digit(key)) begin
                        r_key   <= key;
                        r_state <= ST_KEY_STORE;
                    end else if (alarm_button) begin
                        r_state      <= ST_SHOW_ALARM;
                        r_show_alarm <= 1'b1;
                    end
                end
                ST_KEY_STORE: begin
                    r_count         <= '0;
                    r_state         <= ST_KEY_WAIT;
                    r_show_new_time <= 1'b1;
                end
                ST_KEY_WAIT: begin
                    if (w_timeout) begin
                        r_count         <= '0;
                        r_state         <= ST_IDLE;
                        r_show_new_time <= 1'b0;
                    end else begin
                        if (one_second) begin
                            r_count <= r_count + CNT_W'(1);
                        end
                        if (!is_digit(key)) begin
                            r_state <= ST_KEY_ENTRY;
                        end
                    end
                end
                ST_KEY_ENTRY: begin
                    if (w_timeout) begin
                        r_count         <= '0;
                        r_state         <= ST_IDLE;
                        r_show_new_time <= 1'b0;
                    end else begin
                        if (one_second) begin
                            r_count <= r_count + CNT_W'(1);
                        end
                        if (time_button) begin
                            r_state         <= ST_SET_TIME;
                            r_show_new_time <= 1'b0;
                            r_load_new_c    <= w_valid;
                            r_entry_error   <= !w_valid;
                        end else if (alarm_button) begin
                            r_state         <= ST_SET_ALARM;
                            r_show_new_time <= 1'b0;
                            r_load_new_a    <= w_valid;
                            r_entry_error   <= !w_valid;
                        end else if (is_digit(key)) begin
                            r_key           <= key;
                            r_state         <= ST_KEY_STORE;
                            r_show_new_time <= 1'b0;
                        end
                    end
                end
                ST_SET_TIME, ST_SET_ALARM: begin
                    r_count <= '0;
                    r_state <= ST_IDLE;
                end
                ST_SHOW_ALARM: begin
                    if (!alarm_button) begin
                        r_state      <= ST_IDLE;
                        r_show_alarm <= 1'b0;
                    end
                end
                default: begin
                    r_count         <= '0;
                    r_state         <= ST_IDLE;
                    r_show_new_time <= 1'b0;
                    r_show_alarm    <= 1'b0;
                end
            endcase
        end
    end

    assign new_time_ms_hr  = w_time.ms_hr;
    assign new_time_ls_hr  = w_time.ls_hr;
    assign new_time_ms_min = w_time.ms_min;
    assign new_time_ls_min = w_time.ls_min;
    assign load_new_c      = r_load_new_c;
    assign load_new_a      = r_load_new_a;
    assign entry_error     = r_entry_error;
    assign show_new_time   = r_show_new_time;
    assign show_alarm      = r_show_alarm;

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Directed, table-driven bench for the time-entry sequencer.
module tb_time_entry_ctrl;

    localparam int unsigned T_SEC = 10;
    localparam logic [3:0]  NK    = 4'hA;

    logic       clk = 1'b0;
    logic       reset;
    logic       one_second;
    logic [3:0] key;
    logic       time_button;
    logic       alarm_button;
    logic [3:0] new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min;
    logic       load_new_c, load_new_a, show_new_time, show_alarm, entry_error;

    time_entry_ctrl #(.TIMEOUT_SEC(T_SEC)) dut (
        .clk             (clk),
        .reset           (reset),
        .one_second      (one_second),
        .key             (key),
        .time_button     (time_button),
        .alarm_button    (alarm_button),
        .new_time_ms_hr  (new_time_ms_hr),
        .new_time_ls_hr  (new_time_ls_hr),
        .new_time_ms_min (new_time_ms_min),
        .new_time_ls_min (new_time_ls_min),
        .load_new_c      (load_new_c),
        .load_new_a      (load_new_a),
        .show_new_time   (show_new_time),
        .show_alarm      (show_alarm),
        .entry_error     (entry_error)
    );

    always #5 clk = ~clk;

    // One row = inputs for one cycle and outputs expected after that edge.
    // flags = {load_new_c, load_new_a, entry_error, show_new_time, show_alarm}
    typedef struct {
        logic [3:0]  key;
        logic        tb;
        logic        ab;
        logic        os;
        logic [4:0]  flags;
        logic [15:0] bufv;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_c = 0, n_a = 0, n_e = 0;

    // Count strobe cycles away from the active edge.
    always @(negedge clk) begin
        if (load_new_c)  n_c++;
        if (load_new_a)  n_a++;
        if (entry_error) n_e++;
    end

    function automatic logic [20:0] outs();
        return {load_new_c, load_new_a, entry_error, show_new_time, show_alarm,
                new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min};
    endfunction

    task automatic chk(input string name, input logic [20:0] act, input logic [20:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] k, input logic tb, input logic ab, input logic os);
        key = k; time_button = tb; alarm_button = ab; one_second = os;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] k, input logic tb, input logic ab, input logic os,
                       input logic [4:0] f, input logic [15:0] b);
        vec_t v;
        v.key = k; v.tb = tb; v.ab = ab; v.os = os; v.flags = f; v.bufv = b;
        vecs.push_back(v);
    endtask

    // Digit held three cycles then released: STORE, WAIT, WAIT, ENTRY.
    task automatic digit(input logic [3:0] d, input logic [15:0] prev, input logic [15:0] nxt);
        add(d,  0, 0, 0, 5'b00000, prev);
        add(d,  0, 0, 0, 5'b00010, nxt);
        add(d,  0, 0, 0, 5'b00010, nxt);
        add(NK, 0, 0, 0, 5'b00010, nxt);
    endtask

    task automatic pulses(input int n, input logic [15:0] b);
        for (int p = 0; p < n; p++) begin
            add(NK, 0, 0, 1, 5'b00010, b);
            add(NK, 0, 0, 0, 5'b00010, b);
        end
    endtask

    task automatic press(input logic [3:0] d);
        drive(d, 0, 0, 0);
        repeat (3) step();
        drive(NK, 0, 0, 0);
        step();
    endtask

    int sc, sa, se;

    initial begin
        reset = 1'b1;
        drive(NK, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", outs(), 21'h0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("idle_after_reset", outs(), 21'h0);

        // time_button alone in IDLE is ignored
        add(NK, 1, 0, 0, 5'b00000, 16'h0000);
        add(NK, 0, 0, 0, 5'b00000, 16'h0000);
        // 12:34 -> time load
        digit(4'd1, 16'h0000, 16'h0001);
        digit(4'd2, 16'h0001, 16'h0012);
        digit(4'd3, 16'h0012, 16'h0123);
        digit(4'd4, 16'h0123, 16'h1234);
        add(NK, 1, 0, 0, 5'b10000, 16'h1234);
        add(NK, 0, 0, 0, 5'b00000, 16'h0000);
        // 24:00 -> alarm rejected
        digit(4'd2, 16'h0000, 16'h0002);
        digit(4'd4, 16'h0002, 16'h0024);
        digit(4'd0, 16'h0024, 16'h0240);
        digit(4'd0, 16'h0240, 16'h2400);
        add(NK, 0, 1, 0, 5'b00100, 16'h2400);
        add(NK, 0, 0, 0, 5'b00000, 16'h0000);
        // 23:59 -> alarm load
        digit(4'd2, 16'h0000, 16'h0002);
        digit(4'd3, 16'h0002, 16'h0023);
        digit(4'd5, 16'h0023, 16'h0235);
        digit(4'd9, 16'h0235, 16'h2359);
        add(NK, 0, 1, 0, 5'b01000, 16'h2359);
        add(NK, 0, 0, 0, 5'b00000, 16'h0000);
        // Show alarm for 5 cycles; digits during it are ignored
        add(NK, 0, 1, 0, 5'b00001, 16'h0000);
        for (int r = 0; r < 4; r++) add(4'd3, 0, 1, 0, 5'b00001, 16'h0000);
        add(NK, 0, 0, 0, 5'b00000, 16'h0000);
        add(NK, 0, 0, 0, 5'b00000, 16'h0000);
        // 08:30 with both buttons -> time load only
        digit(4'd0, 16'h0000, 16'h0000);
        digit(4'd8, 16'h0000, 16'h0008);
        digit(4'd3, 16'h0008, 16'h0083);
        digit(4'd0, 16'h0083, 16'h0830);
        add(NK, 1, 1, 0, 5'b10000, 16'h0830);
        add(NK, 0, 0, 0, 5'b00000, 16'h0000);
        // Timeout after T_SEC pulses
        digit(4'd5, 16'h0000, 16'h0005);
        pulses(T_SEC - 1, 16'h0005);
        add(NK, 0, 0, 1, 5'b00010, 16'h0005);
        add(NK, 0, 0, 0, 5'b00000, 16'h0000);
        add(NK, 0, 0, 0, 5'b00000, 16'h0000);
        // A digit before the last pulse restarts the count
        digit(4'd5, 16'h0000, 16'h0005);
        pulses(T_SEC - 1, 16'h0005);
        digit(4'd6, 16'h0005, 16'h0056);
        pulses(T_SEC - 1, 16'h0056);
        add(NK, 1, 0, 0, 5'b10000, 16'h0056);
        add(NK, 0, 0, 0, 5'b00000, 16'h0000);

        foreach (vecs[i]) begin
            drive(vecs[i].key, vecs[i].tb, vecs[i].ab, vecs[i].os);
            step();
            chk($sformatf("row%0d", i), outs(), {vecs[i].flags, vecs[i].bufv});
        end

        // Held key stores once
        press(4'd1);
        drive(4'd7, 0, 0, 0);
        step();
        step();
        chk("hold7_shift", outs(), {5'b00010, 16'h0017});
        repeat (18) step();
        chk("hold7_end", outs(), {5'b00010, 16'h0017});
        drive(4'hF, 0, 0, 0);
        step();
        chk("hold7_release", outs(), {5'b00010, 16'h0017});
        drive(NK, 1, 0, 0);
        step();
        chk("hold7_load", outs(), {5'b10000, 16'h0017});
        drive(NK, 0, 0, 0);
        step();
        chk("hold7_idle", outs(), 21'h0);

        chk_int("strobe_c_cycles", n_c, 4);
        chk_int("strobe_a_cycles", n_a, 1);
        chk_int("error_cycles", n_e, 1);

        // Reset mid-entry with a button pending
        press(4'd1);
        press(4'd2);
        chk("pre_reset_entry", outs(), {5'b00010, 16'h0012});
        sc = n_c; sa = n_a; se = n_e;
        drive(NK, 1, 0, 0);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset", outs(), 21'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) step();
        drive(NK, 0, 0, 0);
        repeat (3) step();
        chk("post_reset_idle", outs(), 21'h0);
        chk_int("post_reset_strobes", (n_c - sc) + (n_a - sa) + (n_e - se), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/time_entry_ctrl.md
Name: time_entry_ctrl

Overview:
- Keypad/button sequencer for the alarm clock.
- Collects up to four BCD digits from the keypad into a shift buffer and presents them as a candidate HH:MM time.
- On a button press, range-checks the candidate and pulses a load strobe: load_new_c into the time-counter block, or load_new_a into the alarm register.
- Also drives display-select controls and abandons an entry after a keypad timeout.

Parameters:
- TIMEOUT_SEC, 10, seconds with no keypad activity before an entry is abandoned; legal range 1-31.
- NOKEY, 4'd10, key code meaning "no key pressed"; any key value above 9 is treated as NOKEY.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- one_second  input  1  single-cycle pulse, once per second
- key  input  4  keypad code: 0-9 digit, otherwise no key
- time_button  input  1  level; request to set the current time from the buffer
- alarm_button  input  1  level; set the alarm from the buffer, or show the alarm when idle
- new_time_ms_hr  output  4  buffer digit 3 (oldest)
- new_time_ls_hr  output  4  buffer digit 2
- new_time_ms_min  output  4  buffer digit 1
- new_time_ls_min  output  4  buffer digit 0 (newest)
- load_new_c  output  1  one-cycle strobe; load the current-time counter
- load_new_a  output  1  one-cycle strobe; load the alarm register
- show_new_time  output  1  display selects the entry buffer
- show_alarm  output  1  display selects the alarm time
- entry_error  output  1  one-cycle pulse; candidate time out of range, nothing loaded

Behaviour:
- Reset (async, active-high):
  - state=IDLE; buffer=16'h0000; timeout count=0.
  - All 1-bit outputs 0; new_time_* all 0.
- Outputs are a Moore decode of the state register plus the registered buffer. No input-to-output combinational path.
- States and transitions (evaluated each clk edge):
  - IDLE:
    - digit key -> KEY_STORE.
    - else alarm_button -> SHOW_ALARM.
    - time_button alone is ignored.
  - KEY_STORE (1 cycle):
    - buffer <= {buffer[11:0], key}; timeout count <= 0.
    - -> KEY_WAIT.
  - KEY_WAIT:
    - Waits for key==NOKEY -> KEY_ENTRY.
    - A held key never stores twice.
  - KEY_ENTRY (show_new_time=1; KEY_WAIT also drives show_new_time=1):
    - time_button -> SET_TIME.
    - else alarm_button -> SET_ALARM.
    - else digit key -> KEY_STORE.
    - Buttons have priority over digits; time_button has priority over alarm_button.
  - SET_TIME (1 cycle):
    - Candidate valid -> load_new_c=1; else entry_error=1.
    - -> IDLE.
  - SET_ALARM (1 cycle):
    - Candidate valid -> load_new_a=1; else entry_error=1.
    - -> IDLE.
  - SHOW_ALARM:
    - show_alarm=1 while alarm_button is held.
    - Release -> IDLE.
    - Keys are ignored.
- Timeout:
  - In KEY_WAIT and KEY_ENTRY, each one_second pulse increments the count (5-bit).
  - When count==TIMEOUT_SEC, the next state is IDLE with no load and no error.
  - Timeout has priority over every other transition from those states.
  - Count is cleared in KEY_STORE and on entry to IDLE.
- Buffer:
  - Cleared to 0 on every entry into IDLE (after a load, an error or a timeout).
  - More than 4 digits: the oldest digit shifts out.
  - Fewer than 4 digits: leading zeros, e.g. 4,5 -> 00:45.
- Validity check (combinational on the registered buffer):
  - ms_hr<=2.
  - ls_hr<=9; ls_hr<=3 when ms_hr==2.
  - ms_min<=5.
  - ls_min<=9.
- Latency:
  - Button sampled in KEY_ENTRY -> strobe on the next cycle.
  - Strobe is exactly 1 cycle wide.
  - new_time_* are stable during the strobe cycle.
- Reset mid-entry: immediate return to IDLE; no strobe is emitted.

Decomposition:
- Shared package/include:
  - State encodings (IDLE, KEY_STORE, KEY_WAIT, KEY_ENTRY, SET_TIME, SET_ALARM, SHOW_ALARM; 3-bit binary).
  - NOKEY constant.
  - Time-limit constants: 2, 3, 5, 9.
- Sub-module key_shift_reg:
  - Contains the 16-bit buffer with shift and clear controls.
  - Contains the validity checker.
- time_entry_ctrl keeps the FSM and the timeout counter.

Test Plan:
- Keys 1,2,3,4 (each held 3 cycles, then NOKEY), then time_button -> load_new_c high exactly 1 cycle; new_time = 1,2,3,4 during the strobe; no entry_error.
- Keys 2,4,0,0, then alarm_button -> entry_error 1 cycle (24:00 invalid); load_new_a stays 0; back in IDLE with buffer 0000.
- Keys 2,3,5,9, then alarm_button -> load_new_a pulse with 23:59. Key 7 held 20 cycles -> buffer shifts exactly once.
- Key 5, then TIMEOUT_SEC one_second pulses with no key -> IDLE; show_new_time drops; no strobe. With 9 pulses and key 6 before the 10th, the count restarts and the entry continues.
- Both buttons in KEY_ENTRY with buffer 0,8,3,0 -> load_new_c only. Assert reset mid-entry after 2 digits -> all outputs 0 immediately; no strobe after release.
- IDLE with alarm_button held 5 cycles -> show_alarm=1 for 5 cycles, then 0; keys pressed meanwhile are not stored.
